// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx, uart_rx and uart_baud_counter.
//   uart_state_t         : frame state encoding. PARITY is always encoded so
//                          that both parity and non-parity builds share one
//                          encoding.
//   DEFAULT_CLKS_PER_BIT : default clk_in cycles per bit period.
//   IDLE_LEVEL           : level of the serial line when no frame is sent.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int   DEFAULT_CLKS_PER_BIT = 32;
   localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by uart_tx and uart_rx.
//   clk_in  : system clock, rising edge
//   rst_in  : synchronous active-low reset
//   clear   : hold the count at zero
//   enable  : advance the count
//   tick    : high on the last cycle of each bit period
// The count runs 0..CLKS_PER_BIT-1 and wraps to 0 on tick.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   always_ff @(posedge clk_in) begin
      if (!rst_in || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, one start bit, one stop bit.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
//   clk_in    : system clock, rising edge
//   rst_in    : synchronous active-low reset
//   data_in   : byte to send, sampled on the accept cycle
//   valid_in  : producer has data_in valid
//   ready_out : transmitter can accept a byte this cycle
//   tx_out    : registered serial line, idle high
//   busy_out  : frame in progress (state other than IDLE)
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (low) for one bit period
// DATA   | DATA_BITS data bits, LSB first
// PARITY | even parity bit (only reachable with UART_TX_PARITY_EN)
// STOP   | stop bit (high); last cycle can accept the next byte
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic                 tx_out,
   output logic                 busy_out
);

   localparam int            BW       = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   uart_state_t          state;
   uart_state_t          state_nx;
   logic [DATA_BITS-1:0] shift;
   logic [BW-1:0]        bit_cnt;
   logic                 tick;
   logic                 accept;
   logic                 tx_nx;
`ifdef UART_TX_PARITY_EN
   logic                 parity;
`endif

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (state == IDLE),
      .enable (state != IDLE),
      .tick   (tick)
   );

   assign accept   = valid_in && ready_out;
   assign busy_out = (state != IDLE);

   // tx_nx is the level for the current state; registering it puts the
   // start bit on the edge after accept and keeps every bit full length.
   always_comb begin
      state_nx  = state;
      ready_out = 1'b0;
      tx_nx     = IDLE_LEVEL;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) state_nx = START;
         end
         START: begin
            tx_nx = 1'b0;
            if (tick) state_nx = DATA;
         end
         DATA: begin
            tx_nx = shift[0];
            if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
         end
         PARITY: begin
`ifdef UART_TX_PARITY_EN
            tx_nx = parity;
`endif
            if (tick) state_nx = STOP;
         end
         STOP: begin
            // Final stop cycle doubles as a handover slot for back-to-back frames.
            if (tick) begin
               ready_out = 1'b1;
               state_nx  = valid_in ? START : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state   <= IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         tx_out  <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         tx_out <= tx_nx;
         if (accept) begin
            shift   <= data_in;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= ^data_in;
`endif
         end else if ((state == DATA) && tick) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   localparam int CPB = 32;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME    = 11 * CPB;
   localparam int STOP_CNT = 16 + 32 * 10;
`else
   localparam int FRAME    = 10 * CPB;
   localparam int STOP_CNT = 16 + 32 * 9;
`endif

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic       tx_out;
   logic       busy_out;

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .tx_out    (tx_out),
      .busy_out  (busy_out)
   );

   always #5 clk_in = ~clk_in;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int acc_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   always @(posedge clk_in) begin
      cyc++;
      if (rst_in && valid_in && ready_out) acc_cnt++;
   end

   // Line monitor: a receiver model that samples mid-bit and scores frames.
   logic       mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte;
   logic [7:0] exp_b;
   int         last_fall = 0;
   int         prev_fall = 0;
   int         frames = 0;

   always @(negedge clk_in) begin
      if (!rst_in) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx_out == 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            prev_fall  = last_fall;
            last_fall  = cyc;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 16) begin
            check("start_bit", {31'd0, tx_out}, 32'd0);
         end else if (mon_cnt > 16 && mon_cnt <= 16 + 32 * 8 && (mon_cnt - 16) % 32 == 0) begin
            mon_byte = {tx_out, mon_byte[7:1]};
`ifdef UART_TX_PARITY_EN
         end else if (mon_cnt == 16 + 32 * 9) begin
            check("parity_bit", {31'd0, tx_out}, {31'd0, ^mon_byte});
`endif
         end else if (mon_cnt == STOP_CNT) begin
            check("stop_bit", {31'd0, tx_out}, 32'd1);
            if (exp_q.size() == 0) begin
               timeout("unexpected_frame");
            end else begin
               exp_b = exp_q.pop_front();
               check("rx_byte", {24'd0, mon_byte}, {24'd0, exp_b});
            end
            frames++;
            mon_active = 1'b0;
         end
      end
   end

   // Offer a byte; after the accept edge optionally drop valid_in.
   task automatic send(input logic [7:0] b, input logic drop);
      int n = 0;
      @(negedge clk_in);
      data_in  = b;
      valid_in = 1'b1;
      while (!ready_out && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 2000) begin
         timeout("send_ready");
         valid_in = 1'b0;
      end else begin
         exp_q.push_back(b);
         @(posedge clk_in);
         #1;
         if (drop) valid_in = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy_out || mon_active) && n < 3000) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 3000) timeout("drain");
      repeat (4) @(negedge clk_in);
   endtask

   // Called right after an accept edge: measures busy length, first
   // ready return and length of the start bit.
   task automatic measure(output int busy_n, output int ready_at, output int low_n);
      logic seen_high;
      busy_n    = 0;
      ready_at  = -1;
      low_n     = 0;
      seen_high = 1'b0;
      @(negedge clk_in);
      while (busy_out && busy_n < 1000) begin
         busy_n++;
         if (ready_out && ready_at < 0) ready_at = busy_n;
         if (tx_out == 1'b0 && !seen_high) low_n++;
         if (tx_out == 1'b1 && low_n > 0) seen_high = 1'b1;
         @(negedge clk_in);
      end
   endtask

   initial begin
      int busy_n, ready_at, low_n, a0, lows;

      // 1. reset
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_tx", {31'd0, tx_out}, 32'd1);
      check("rst_ready", {31'd0, ready_out}, 32'd1);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);

      // 2. single byte, data_in changes after accept
      send(8'h53, 1'b1);
      data_in = 8'h00;
      measure(busy_n, ready_at, low_n);
      check("busy_len", busy_n, FRAME);
      check("ready_return", ready_at, FRAME);
      check("start_len", low_n, CPB);
      drain();

      // 3. back-to-back with valid held
      a0 = acc_cnt;
      send(8'hA5, 1'b0);
      send(8'h0F, 1'b1);
      drain();
      check("b2b_gap", last_fall - prev_fall, FRAME);
      check("b2b_accepts", acc_cnt - a0, 2);

      // 4. reset during data bit 3 of 0xFF
      send(8'hFF, 1'b1);
      repeat (140) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      check("abort_tx", {31'd0, tx_out}, 32'd1);
      check("abort_busy", {31'd0, busy_out}, 32'd0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      exp_q.delete();
      lows = 0;
      repeat (400) begin
         @(negedge clk_in);
         if (tx_out == 1'b0) lows++;
      end
      check("abort_no_low", lows, 0);
      a0 = frames;
      send(8'h55, 1'b1);
      drain();
      check("post_abort_frames", frames - a0, 1);

      // 5. loopback-style sequence through the line model
      a0 = frames;
      send(8'h00, 1'b1);
      drain();
      send(8'hFF, 1'b1);
      drain();
      send(8'h53, 1'b1);
      drain();
      check("loop_frames", frames - a0, 3);

`ifdef UART_TX_PARITY_EN
      // 6. parity frames
      send(8'h53, 1'b1);
      measure(busy_n, ready_at, low_n);
      check("par_frame_len", busy_n, 352);
      drain();
      send(8'h07, 1'b1);
      drain();
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 by default, LSB first, fixed baud set by a clock-count parameter.
- Sits directly upstream of uart_rx. Its tx_out drives the rx_in line, so the pair can run as a loopback in sim and on the board.
- Takes bytes from a valid/ready producer (control FSM or host bridge) and serialises them onto the line.

Parameters:
- CLKS_PER_BIT, 32, clk_in cycles per bit period; legal range 2 or more.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous active-low reset; sampled on the rising edge of clk_in, 0 = reset.
- data_in  input  DATA_BITS  byte to send; sampled on the accept cycle.
- valid_in  input  1  producer has data_in valid.
- ready_out  output  1  transmitter can accept a byte this cycle.
- tx_out  output  1  serial line; idle high; registered.
- busy_out  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - tx_out=1, ready_out=1, busy_out=0.
  - State goes to IDLE; bit counter, clock counter and shift register are cleared.
  - Reset during a frame aborts it immediately; the line returns high on the next edge and no partial frame resumes.
- Accept: the edge on which valid_in=1 and ready_out=1. data_in is loaded into the shift register.
- States:
  - IDLE: tx_out=1, ready_out=1. On accept, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After DATA_BITS bits, go to PARITY (if the macro is defined) or STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx_out falls on the first edge after the accept edge. The frame is (2+DATA_BITS)*CLKS_PER_BIT cycles (320 at defaults), or one extra bit period with parity.
- Clock counter runs 0..CLKS_PER_BIT-1. Wrap to 0 marks a bit boundary. The counter is $clog2(CLKS_PER_BIT) bits wide.
- Back-to-back frames:
  - ready_out is also 1 during the final cycle of STOP.
  - An accept in that cycle goes straight to START with no extra idle cycle. The stop bit keeps its full length.
- ready_out=0 in all other non-IDLE cycles. A valid_in held high during those cycles is ignored and not lost: the producer holds it until accept.
- data_in changing after accept has no effect on the frame in flight.
- busy_out=0 only in IDLE. It stays 1 through the back-to-back handover cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and lasts CLKS_PER_BIT cycles.
  - tx_out = XOR of the DATA_BITS data bits (even parity), computed at accept and registered.
- Undefined: no PARITY state and no parity logic; frame is 8N1.
- The matching uart_rx build uses the same macro.

Decomposition:
- Package uart_pkg holds:
  - the state typedef (enum IDLE, START, DATA, PARITY, STOP; PARITY encoded even when the macro is off);
  - constant DEFAULT_CLKS_PER_BIT=32, shared with uart_rx;
  - constant IDLE_LEVEL=1'b1.
- One sub-module, uart_baud_counter, shared with uart_rx:
  - inputs clk_in, rst_in, clear, enable;
  - output tick on the last cycle of each bit period.
- uart_tx instantiates uart_baud_counter and holds the FSM, shift register and bit counter.

Test Plan:
1. Reset: hold rst_in=0 for 2 cycles mid-idle -> tx_out=1, ready_out=1, busy_out=0.
2. Single byte 0x53, one-cycle valid_in -> line reads start 0, bits 1,1,0,0,1,0,1,0, stop 1.
   - Each bit lasts exactly 32 cycles.
   - busy_out is high for 320 cycles; ready_out returns high in cycle 320.
3. Back-to-back 0xA5 then 0x0F, valid_in held high -> second start bit immediately follows the 32-cycle stop, with zero idle cycles. Exactly 2 accepts counted.
4. Reset mid-frame: assert rst_in=0 during data bit 3 of 0xFF -> tx_out=1 on the next edge; no further low bits; a fresh 0x55 then transmits cleanly.
5. Loopback: tx_out to uart_rx.rx_in, send 0x00, 0xFF, 0x53 -> uart_rx reports the same three bytes in order with no framing error.
6. With UART_TX_PARITY_EN, send 0x53 (four ones) -> parity bit 0, frame 352 cycles. Send 0x07 -> parity bit 1.
